// File: rtl/product_mem_pkg.sv
// Shared definitions for the product memory responder and the multiplier that drives it.
package product_mem_pkg;

    localparam int DEFAULT_LOGDEPTH = 6;
    localparam int DEFAULT_WIDTH    = 32;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } mem_state_t;

endpackage

// File: rtl/product_mem_rd_pipe.sv
// Fixed-latency read return pipeline: READ_LAT stages of valid/data, flushed by rst.
// The output data register only loads when a valid result arrives, so it holds between reads.
module product_mem_rd_pipe #(
    parameter int WIDTH    = 32,
    parameter int READ_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [READ_LAT-1:0]            valid_q;
    logic [READ_LAT-1:0][WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[READ_LAT-1];
    assign out_data  = data_q[READ_LAT-1];

endmodule

// File: rtl/product_mem_responder.sv
// Memory-side responder for product writeMem/readMem traffic with block fill/drain tracking.
// Define PRODUCT_MEM_RD_BYPASS_EN for write-first same-address read behaviour (default read-first).
module product_mem_responder
    import product_mem_pkg::*;
#(
    parameter int LOGDEPTH = DEFAULT_LOGDEPTH,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_block,
    input  logic                EN_writeMem,
    input  logic [LOGDEPTH-1:0] writeMem_addr,
    input  logic [WIDTH-1:0]    writeMem_val,
    input  logic                EN_readMem,
    input  logic [LOGDEPTH-1:0] readMem_addr,
    output logic [WIDTH-1:0]    readMem_val,
    output logic                rd_valid,
    output logic                mem_full,
    output logic                mem_empty,
    output logic [LOGDEPTH:0]   wr_count,
    output logic                wr_seq_err,
    output logic                wr_drop_err,
    output logic                rd_unwritten_err
);

    localparam int DEPTH = 2 ** LOGDEPTH;
    localparam logic [LOGDEPTH:0]   FULL_COUNT = (LOGDEPTH + 1)'(DEPTH);
    localparam logic [LOGDEPTH-1:0] LAST_ADDR  = LOGDEPTH'(DEPTH - 1);

    if ((READ_LAT != 1) && (READ_LAT != 2)) begin : g_bad_read_lat
        $error("product_mem_responder: READ_LAT must be 1 or 2");
    end

    mem_state_t state;
    mem_state_t next_state;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH-1:0]    written;
    logic [LOGDEPTH:0]   count;
    logic [LOGDEPTH-1:0] exp_addr;
    logic                seq_err;
    logic                drop_err;
    logic                unwr_err;

    logic                wr_open;
    logic                wr_accept;
    logic                wr_drop;
    logic                wr_new;
    logic [LOGDEPTH:0]   count_inc;
    logic                drain_done;
    logic                rd_hit;
    logic                rd_bypass;
    logic                rd_unwritten;
    logic [WIDTH-1:0]    rd_data;

    // clr_block and rst both suppress a same-cycle write without flagging it.
    assign wr_open    = (state == EMPTY) || (state == FILLING);
    assign wr_accept  = EN_writeMem && !rst && !clr_block && wr_open;
    assign wr_drop    = EN_writeMem && !clr_block && !wr_open;
    assign wr_new     = wr_accept && !written[writeMem_addr];
    assign count_inc  = (wr_new && (count != FULL_COUNT)) ? count + (LOGDEPTH + 1)'(1) : count;
    assign drain_done = EN_readMem && (state == DRAINING) && (readMem_addr == LAST_ADDR);

`ifdef PRODUCT_MEM_RD_BYPASS_EN
    assign rd_bypass = wr_accept && (writeMem_addr == readMem_addr);
`else
    assign rd_bypass = 1'b0;
`endif

    // The written-bit check deliberately uses the bitmap before this cycle's write.
    assign rd_hit       = written[readMem_addr];
    assign rd_unwritten = EN_readMem && !rd_hit && !rd_bypass;

    always_comb begin
        rd_data = '0;
        if (rd_bypass) begin
            rd_data = writeMem_val;
        end else if (rd_hit) begin
            rd_data = mem[readMem_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[writeMem_addr] <= writeMem_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (clr_block) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY, FILLING: begin
                    if (wr_accept) begin
                        next_state = (count_inc == FULL_COUNT) ? FULL : FILLING;
                    end
                end
                FULL: begin
                    if (EN_readMem) begin
                        next_state = DRAINING;
                    end
                end
                DRAINING: begin
                    if (drain_done) begin
                        next_state = EMPTY;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    always_comb begin
        mem_full  = (state == FULL);
        mem_empty = (state == EMPTY);
    end

    // Block bookkeeping; a completed drain clears the block but keeps the sticky errors.
    always_ff @(posedge clk) begin
        if (rst || clr_block) begin
            written  <= '0;
            count    <= '0;
            exp_addr <= '0;
            seq_err  <= 1'b0;
            drop_err <= 1'b0;
            unwr_err <= 1'b0;
        end else begin
            if (drain_done) begin
                written  <= '0;
                count    <= '0;
                exp_addr <= '0;
            end else if (wr_accept) begin
                written[writeMem_addr] <= 1'b1;
                count                  <= count_inc;
                exp_addr               <= writeMem_addr + LOGDEPTH'(1);
                if (writeMem_addr != exp_addr) begin
                    seq_err <= 1'b1;
                end
            end
            if (wr_drop) begin
                drop_err <= 1'b1;
            end
            if (rd_unwritten) begin
                unwr_err <= 1'b1;
            end
        end
    end

    assign wr_count         = count;
    assign wr_seq_err       = seq_err;
    assign wr_drop_err      = drop_err;
    assign rd_unwritten_err = unwr_err;

    product_mem_rd_pipe #(
        .WIDTH    (WIDTH),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (EN_readMem),
        .in_data   (rd_data),
        .out_valid (rd_valid),
        .out_data  (readMem_val)
    );

endmodule

// File: tb/tb_product_mem_responder.sv
// Self-checking bench for product_mem_responder: READ_LAT=1 and READ_LAT=2 instances in lockstep
// against a behavioural block model (honours PRODUCT_MEM_RD_BYPASS_EN).
module tb_product_mem_responder;
    import product_mem_pkg::*;

    localparam int LOGDEPTH  = DEFAULT_LOGDEPTH;
    localparam int WIDTH     = DEFAULT_WIDTH;
    localparam int DEPTH     = 2 ** LOGDEPTH;
    localparam int MAX_CALLS = 4096;

    localparam int M_EMPTY    = 0;
    localparam int M_FILLING  = 1;
    localparam int M_FULL     = 2;
    localparam int M_DRAINING = 3;

`ifdef PRODUCT_MEM_RD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                clr_block = 1'b0;
    logic                EN_writeMem = 1'b0;
    logic [LOGDEPTH-1:0] writeMem_addr = '0;
    logic [WIDTH-1:0]    writeMem_val = '0;
    logic                EN_readMem = 1'b0;
    logic [LOGDEPTH-1:0] readMem_addr = '0;

    logic [WIDTH-1:0]    readMem_val_1, readMem_val_2;
    logic                rd_valid_1, rd_valid_2;
    logic                mem_full_1, mem_full_2;
    logic                mem_empty_1, mem_empty_2;
    logic [LOGDEPTH:0]   wr_count_1, wr_count_2;
    logic                wr_seq_err_1, wr_seq_err_2;
    logic                wr_drop_err_1, wr_drop_err_2;
    logic                rd_unwritten_err_1, rd_unwritten_err_2;

    product_mem_responder #(.LOGDEPTH(LOGDEPTH), .WIDTH(WIDTH), .READ_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst), .clr_block(clr_block),
        .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
        .EN_readMem(EN_readMem), .readMem_addr(readMem_addr),
        .readMem_val(readMem_val_1), .rd_valid(rd_valid_1),
        .mem_full(mem_full_1), .mem_empty(mem_empty_1), .wr_count(wr_count_1),
        .wr_seq_err(wr_seq_err_1), .wr_drop_err(wr_drop_err_1),
        .rd_unwritten_err(rd_unwritten_err_1)
    );

    product_mem_responder #(.LOGDEPTH(LOGDEPTH), .WIDTH(WIDTH), .READ_LAT(2)) dut_lat2 (
        .clk(clk), .rst(rst), .clr_block(clr_block),
        .EN_writeMem(EN_writeMem), .writeMem_addr(writeMem_addr), .writeMem_val(writeMem_val),
        .EN_readMem(EN_readMem), .readMem_addr(readMem_addr),
        .readMem_val(readMem_val_2), .rd_valid(rd_valid_2),
        .mem_full(mem_full_2), .mem_empty(mem_empty_2), .wr_count(wr_count_2),
        .wr_seq_err(wr_seq_err_2), .wr_drop_err(wr_drop_err_2),
        .rd_unwritten_err(rd_unwritten_err_2)
    );

    always #5 clk = ~clk;

    int               m_state = M_EMPTY;
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_written [DEPTH];
    int               m_exp = 0;
    bit               m_seq = 0;
    bit               m_drop = 0;
    bit               m_unwr = 0;

    // Read results indexed by the call in which the request was made.
    bit               hist_valid [MAX_CALLS];
    logic [WIDTH-1:0] hist_data [MAX_CALLS];
    logic [WIDTH-1:0] last1 = '0;
    logic [WIDTH-1:0] last2 = '0;
    int               ncall = 0;

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s (call %0d): observed %0h, expected %0h", tag, ncall, observed, expected);
        end
    endtask

    function automatic int writtenCount();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_written[i]);
        return n;
    endfunction

    task automatic clearBlock();
        for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;
        m_exp = 0;
    endtask

    task automatic applyStimulus(input bit r, input bit c, input bit we, input int wa,
                                 input logic [WIDTH-1:0] wd, input bit re, input int ra);
        int               pre;
        bit               wacc;
        logic [WIDTH-1:0] rdat;
        bit               v2;

        rst           = r;
        clr_block     = c;
        EN_writeMem   = we;
        writeMem_addr = wa[LOGDEPTH-1:0];
        writeMem_val  = wd;
        EN_readMem    = re;
        readMem_addr  = ra[LOGDEPTH-1:0];

        pre  = m_state;
        rdat = '0;
        hist_valid[ncall] = 1'b0;
        hist_data[ncall]  = '0;
        if (r) begin
            m_state = M_EMPTY;
            clearBlock();
            m_seq = 0; m_drop = 0; m_unwr = 0;
            if (ncall > 0) hist_valid[ncall-1] = 1'b0;
            last1 = '0;
            last2 = '0;
        end else begin
            wacc = we && !c && (pre == M_EMPTY || pre == M_FILLING);
            if (re) begin
                if (BYPASS && wacc && (wa == ra)) rdat = wd;
                else if (m_written[ra]) rdat = m_mem[ra];
                else m_unwr = 1;
                hist_valid[ncall] = 1'b1;
                hist_data[ncall]  = rdat;
            end
            if (c) begin
                m_state = M_EMPTY;
                clearBlock();
                m_seq = 0; m_drop = 0; m_unwr = 0;
            end else begin
                if (wacc) begin
                    m_mem[wa] = wd;
                    m_written[wa] = 1'b1;
                    if (wa != m_exp) m_seq = 1;
                    m_exp = (wa + 1) % DEPTH;
                    m_state = (writtenCount() == DEPTH) ? M_FULL : M_FILLING;
                end else if (we) begin
                    m_drop = 1;
                end
                if (re && pre == M_FULL) begin
                    m_state = M_DRAINING;
                end else if (re && pre == M_DRAINING && ra == DEPTH - 1) begin
                    m_state = M_EMPTY;
                    clearBlock();
                end
            end
        end

        @(posedge clk);
        #1;

        if (hist_valid[ncall]) last1 = hist_data[ncall];
        v2 = (ncall > 0) ? hist_valid[ncall-1] : 1'b0;
        if (v2) last2 = hist_data[ncall-1];

        checkOutput("rd_valid_lat1", 64'(rd_valid_1), 64'(hist_valid[ncall]));
        checkOutput("rd_data_lat1", 64'(readMem_val_1), 64'(last1));
        checkOutput("rd_valid_lat2", 64'(rd_valid_2), 64'(v2));
        checkOutput("rd_data_lat2", 64'(readMem_val_2), 64'(last2));
        checkOutput("mem_full_1", 64'(mem_full_1), 64'(m_state == M_FULL));
        checkOutput("mem_empty_1", 64'(mem_empty_1), 64'(m_state == M_EMPTY));
        checkOutput("wr_count_1", 64'(wr_count_1), 64'(writtenCount()));
        checkOutput("wr_seq_err_1", 64'(wr_seq_err_1), 64'(m_seq));
        checkOutput("wr_drop_err_1", 64'(wr_drop_err_1), 64'(m_drop));
        checkOutput("rd_unwr_err_1", 64'(rd_unwritten_err_1), 64'(m_unwr));
        checkOutput("mem_full_2", 64'(mem_full_2), 64'(m_state == M_FULL));
        checkOutput("mem_empty_2", 64'(mem_empty_2), 64'(m_state == M_EMPTY));
        checkOutput("wr_count_2", 64'(wr_count_2), 64'(writtenCount()));
        checkOutput("wr_seq_err_2", 64'(wr_seq_err_2), 64'(m_seq));
        checkOutput("wr_drop_err_2", 64'(wr_drop_err_2), 64'(m_drop));
        checkOutput("rd_unwr_err_2", 64'(rd_unwritten_err_2), 64'(m_unwr));
        ncall++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        bit               r, c, we, re;
        int               wa, ra;
        logic [WIDTH-1:0] wd;

        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_written[i] = 1'b0;
        end

        applyStimulus(1, 0, 0, 0, '0, 0, 0);
        applyStimulus(1, 0, 0, 0, '0, 0, 0);

        // Sequential fill, then a back-to-back drain.
        for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, 1, a, WIDTH'(a * 3), 0, 0);
        for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, 0, 0, '0, 1, a);
        idle(2);

        // Out-of-order write, rewrite, unwritten read.
        applyStimulus(0, 0, 1, 0, WIDTH'($urandom), 0, 0);
        applyStimulus(0, 0, 1, 1, WIDTH'($urandom), 0, 0);
        applyStimulus(0, 0, 1, 5, WIDTH'($urandom), 0, 0);
        applyStimulus(0, 0, 1, 1, WIDTH'($urandom), 0, 0);
        applyStimulus(0, 0, 0, 0, '0, 1, 2);
        idle(2);

        // Complete the block, write while FULL, read back the original data, drain via the last address.
        for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, 1, a, WIDTH'(a * 3), 0, 0);
        applyStimulus(0, 0, 1, 10, WIDTH'(32'hDEAD), 0, 0);
        applyStimulus(0, 0, 0, 0, '0, 1, 10);
        applyStimulus(0, 0, 1, 11, WIDTH'(32'hBEEF), 1, DEPTH - 1);
        idle(2);

        // clr_block beats a simultaneous write; then same-cycle write/read of one address.
        applyStimulus(0, 1, 1, 7, WIDTH'(32'h77), 0, 0);
        applyStimulus(0, 0, 1, 4, WIDTH'(32'h11), 0, 0);
        applyStimulus(0, 0, 1, 4, WIDTH'(32'h22), 1, 4);
        idle(2);

        // Reset with two reads in flight in the two-cycle instance.
        applyStimulus(1, 0, 0, 0, '0, 0, 0);
        for (int a = 0; a < 19; a++) applyStimulus(0, 0, 1, a, WIDTH'($urandom), 0, 0);
        applyStimulus(0, 0, 1, 30, WIDTH'($urandom), 0, 0);
        applyStimulus(0, 0, 0, 0, '0, 1, 50);
        applyStimulus(0, 0, 0, 0, '0, 1, 1);
        applyStimulus(1, 0, 0, 0, '0, 1, 2);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 399) == 0);
            c  = ($urandom_range(0, 249) == 0);
            we = ($urandom_range(0, 99) < 60);
            wa = ($urandom_range(0, 9) < 8) ? m_exp : int'($urandom_range(0, DEPTH - 1));
            wd = WIDTH'($urandom);
            re = ($urandom_range(0, 99) < 40);
            ra = int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) == 0) ra = wa;
            if (m_state == M_DRAINING && $urandom_range(0, 7) == 0) ra = DEPTH - 1;
            applyStimulus(r, c, we, wa, wd, re, ra);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/product_mem_responder.md
Name: product_mem_responder

Overview:
- Memory-side responder for the product write/read interface: DEPTH×WIDTH storage that accepts product writes, answers read requests with fixed latency, and tracks block fill/drain status.
- Sits between the multiplier block (initiator of writeMem/readMem traffic) and the storage.
- Flags protocol violations: out-of-order writes, dropped writes, reads of unwritten entries.

Parameters:
- LOGDEPTH, 6, address width; DEPTH = 2**LOGDEPTH.
- WIDTH, 32, data word width.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2 only; elaboration error otherwise.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- clr_block  in  1  forces return to EMPTY; clears status and error flags.
- EN_writeMem  in  1  write request.
- writeMem_addr  in  LOGDEPTH  write address.
- writeMem_val  in  WIDTH  write data.
- EN_readMem  in  1  read request.
- readMem_addr  in  LOGDEPTH  read address.
- readMem_val  out  WIDTH  read data, valid when rd_valid=1.
- rd_valid  out  1  read-data strobe.
- mem_full  out  1  high in FULL state.
- mem_empty  out  1  high in EMPTY state.
- wr_count  out  LOGDEPTH+1  number of distinct entries written in the current block, range 0..DEPTH.
- wr_seq_err  out  1  sticky: accepted write address was not the expected sequential address.
- wr_drop_err  out  1  sticky: write arrived in FULL or DRAINING and was dropped.
- rd_unwritten_err  out  1  sticky: read of an entry whose written bit is 0.

Behaviour:
- Reset (clk, rst synchronous active-high):
  - State EMPTY; written bitmap cleared; expected write address 0; read pipeline flushed.
  - Outputs: readMem_val=0, rd_valid=0, mem_full=0, mem_empty=1, wr_count=0, all error flags 0.
  - Storage array is not reset.
  - Reset mid-operation discards in-flight reads; no rd_valid is issued for them.
- States: EMPTY, FILLING, FULL, DRAINING.
  - EMPTY → FILLING: on any accepted write.
  - FILLING → FULL: in the cycle after wr_count reaches DEPTH.
  - FULL → DRAINING: on the first EN_readMem.
  - DRAINING → EMPTY: on the cycle after a read of address DEPTH-1 is accepted. The bitmap, wr_count and expected address are cleared at that edge; error flags persist.
  - clr_block (any state): next state EMPTY, as reset, but the read pipeline still completes its in-flight reads.
- Writes:
  - Accepted only in EMPTY/FILLING; the array is written at the clock edge.
  - If the address's written bit was 0, set it and increment wr_count. A rewrite overwrites data with no increment.
  - If writeMem_addr ≠ expected address: the write is still accepted and wr_seq_err is set. The expected address then becomes writeMem_addr+1 (mod DEPTH).
  - Writes in FULL or DRAINING are dropped and set wr_drop_err.
- Reads:
  - Accepted in any state. Data and rd_valid appear exactly READ_LAT cycles after the EN_readMem cycle.
  - Back-to-back reads give one result per cycle, in order.
  - Unwritten entry: readMem_val=0, rd_valid=1, rd_unwritten_err set.
  - readMem_val holds its last value when rd_valid=0.
- Simultaneous write and read to the same address in the same cycle: read returns the old contents (read-first) unless RD_BYPASS_EN is defined. Written-bit check uses the pre-write bitmap.
- Simultaneous clr_block and write: clr_block wins and the write is dropped without an error.
- Address arithmetic wraps modulo DEPTH. wr_count saturates at DEPTH.

Optional Feature:
- PRODUCT_MEM_RD_BYPASS_EN defined: a same-cycle same-address write and read return writeMem_val (write-first) and do not set rd_unwritten_err.
- Undefined: read-first behaviour as specified above.

Decomposition:
- Shared package product_mem_pkg:
  - state typedef mem_state_t {EMPTY, FILLING, FULL, DRAINING}.
  - Default LOGDEPTH/WIDTH constants, shared with the multiplier.
- One sub-module, product_mem_rd_pipe: READ_LAT-stage valid/data shift pipeline, with flush on rst.

Test Plan:
- Reset, then write addresses 0..63 with data addr*3 → wr_count steps 0→64; mem_full=1 the cycle after the write to address 63; wr_seq_err=0.
- From FULL, read 0..63 back-to-back (READ_LAT=1) → rd_valid high for 64 consecutive cycles, each starting one cycle after its request; data = addr*3. State returns to EMPTY the cycle after the read of address 63: mem_empty=1, wr_count=0.
- Write addresses 0,1,5 → wr_seq_err=1 after the write to 5. Rewrite address 1 → wr_count stays 3. Read address 2 → readMem_val=0, rd_unwritten_err=1.
- In FULL, write address 10 with 0xDEAD → wr_drop_err=1; a subsequent read of address 10 returns the original data.
- Same-cycle write and read of address 4, old=0x11, new=0x22 → read returns 0x11; with PRODUCT_MEM_RD_BYPASS_EN defined, returns 0x22.
- Reset asserted at wr_count=20 with 2 reads in flight (READ_LAT=2) → no rd_valid afterwards; mem_empty=1; wr_count=0; all error flags 0.
